// File: rtl/debug_view_ctrl_pkg.sv
// Shared widths, FSM/trigger encodings and register-index helper for the
// debug register viewer.
package debug_view_pkg;

  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CAPTURE
  } state_e;

  typedef enum logic [1:0] {
    TRG_INIT,
    TRG_ADV,
    TRG_REFRESH,
    TRG_MANUAL
  } trig_e;

  // Next register index in the scan order, wrapping past the last register.
  function automatic reg_id_t next_reg_id(input reg_id_t id);
    return REG_ID_W'((32'(id) + 32'd1) % NUM_REGS);
  endfunction

endpackage

// File: rtl/debug_view_ctrl_if.sv
// Board-side and core-side signals of the debug viewer; master is the
// environment (board + core), slave is the controller.
interface debug_view_ctrl_if;
  import debug_view_pkg::*;

  logic              step_key_n;
  logic              auto_mode;
  reg_id_t           sw_reg_id;
  reg_id_t           reg_out_id;
  logic [DATA_W-1:0] reg_out_data;
  logic              cpu_step;
  logic [DATA_W-1:0] view_data;
  reg_id_t           view_id;
  logic              view_valid;

  modport master (
    output step_key_n, auto_mode, sw_reg_id, reg_out_data,
    input  reg_out_id, cpu_step, view_data, view_id, view_valid
  );

  modport slave (
    input  step_key_n, auto_mode, sw_reg_id, reg_out_data,
    output reg_out_id, cpu_step, view_data, view_id, view_valid
  );

endinterface

// File: rtl/debug_view_ctrl_key_debouncer.sv
// Step-key synchronizer and debouncer; emits a one-cycle pulse on each
// debounced press (high-to-low of the active-low key).
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced key disagrees with the debounced level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/debug_view_ctrl.sv
// Debug register viewer: debounced CPU stepping plus a capture FSM that
// arbitrates the core's register-read port between switches and auto-scan.
module debug_view_ctrl
  import debug_view_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DWELL_CYCLES    = 50000000
) (
  input logic               clock,
  input logic               reset,
  debug_view_ctrl_if.slave  bus
);

  localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);

  logic               auto_s1_q, auto_s2_q, auto_prev_q;
  reg_id_t            sw_s1_q, sw_s2_q;
  state_e             state_q, state_d;
  reg_id_t            target_q, target_d;
  reg_id_t            reg_out_id_q, reg_out_id_d;
  logic [DATA_W-1:0]  view_data_q, view_data_d;
  reg_id_t            view_id_q, view_id_d;
  logic               view_valid_q, view_valid_d;
  logic               init_q, init_d;
  logic               step_pend_q, step_pend_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cpu_step_w, key_level;
  logic               trig_hit;
  trig_e              trig;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clock   (clock),
    .reset   (reset),
    .key_n_i (bus.step_key_n),
    .level_o (key_level),
    .press_o (cpu_step_w)
  );

  // A step pulse can only exist while the debounced key is held down.
  assert property (@(posedge clock) disable iff (reset) cpu_step_w |-> !key_level);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    view_data_d  = view_data_q;
    view_id_d    = view_id_q;
    view_valid_d = view_valid_q;
    init_d       = init_q;
    step_pend_d  = step_pend_q | cpu_step_w;
    dwell_d      = dwell_q;
    trig_hit     = 1'b1;
    trig         = TRG_INIT;

    // Trigger priority: init, auto advance, step refresh, manual change.
    if (init_q) begin
      trig = TRG_INIT;
    end else if (auto_s2_q && dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
      trig = TRG_ADV;
    end else if (step_pend_q) begin
      trig = TRG_REFRESH;
    end else if (!auto_s2_q && sw_s2_q != view_id_q) begin
      trig = TRG_MANUAL;
    end else begin
      trig_hit = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (trig_hit) begin
          state_d     = SETUP;
          init_d      = 1'b0;
          step_pend_d = 1'b0;
          dwell_d     = '0;
          case (trig)
            TRG_INIT:    target_d = auto_s2_q ? '0 : sw_s2_q;
            TRG_ADV:     target_d = next_reg_id(view_id_q);
            TRG_REFRESH: target_d = auto_s2_q ? view_id_q : sw_s2_q;
            default:     target_d = sw_s2_q;
          endcase
        end else if (auto_s2_q) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      SETUP: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        view_data_d  = bus.reg_out_data;
        view_id_d    = target_q;
        view_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (auto_s2_q != auto_prev_q) begin
      dwell_d = '0;
    end

    // Read port shows the held register when idle, the target otherwise.
    reg_out_id_d = (state_d == IDLE) ? view_id_d : target_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_s1_q    <= 1'b0;
      auto_s2_q    <= 1'b0;
      auto_prev_q  <= 1'b0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      state_q      <= IDLE;
      target_q     <= '0;
      reg_out_id_q <= '0;
      view_data_q  <= '0;
      view_id_q    <= '0;
      view_valid_q <= 1'b0;
      init_q       <= 1'b1;
      step_pend_q  <= 1'b0;
      dwell_q      <= '0;
    end else begin
      auto_s1_q    <= bus.auto_mode;
      auto_s2_q    <= auto_s1_q;
      auto_prev_q  <= auto_s2_q;
      sw_s1_q      <= bus.sw_reg_id;
      sw_s2_q      <= sw_s1_q;
      state_q      <= state_d;
      target_q     <= target_d;
      reg_out_id_q <= reg_out_id_d;
      view_data_q  <= view_data_d;
      view_id_q    <= view_id_d;
      view_valid_q <= view_valid_d;
      init_q       <= init_d;
      step_pend_q  <= step_pend_d;
      dwell_q      <= dwell_d;
    end
  end

  assign bus.reg_out_id = reg_out_id_q;
  assign bus.cpu_step   = cpu_step_w;
  assign bus.view_data  = view_data_q;
  assign bus.view_id    = view_id_q;
  assign bus.view_valid = view_valid_q;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Bench for debug_view_ctrl: randomized key bounce and switch selections
// against a register-file model whose contents the bench controls.
module tb_debug_view_ctrl;
  import debug_view_pkg::*;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DWELL = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;
  int         pulses = 0;
  int         last_step_cyc = -1;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] core_gen = 8'd0;

  debug_view_ctrl_if bus ();

  debug_view_ctrl #(.DEBOUNCE_CYCLES(DEB), .DWELL_CYCLES(DWELL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Core register file: register k holds 0x1000_0000 + k, plus a bench-set generation.
  assign bus.reg_out_data = 32'h1000_0000 + 32'(bus.reg_out_id) + {8'h00, core_gen, 16'h0000};

  always @(negedge clock) begin
    if (bus.cpu_step === 1'b1) begin
      pulses        <= pulses + 1;
      last_step_cyc <= cyc;
    end
  end

  function automatic logic [31:0] exp_val(input reg_id_t id);
    return 32'h1000_0000 + 32'(id) + {8'h00, core_gen, 16'h0000};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_view(input reg_id_t id, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget && !ok; i++) begin
      if (bus.view_valid === 1'b1 && bus.view_id === id) ok = 1'b1;
      else if (i < budget) clk(1);
    end
  endtask

  task automatic bounce(input int toggles);
    for (int i = 0; i < toggles; i++) begin
      bus.step_key_n = ~bus.step_key_n;
      clk($urandom_range(1, 3));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit      ok;
    int      t0, p0;
    reg_id_t last_id, id_b, id_c;
    logic [31:0] e;

    bus.step_key_n = 1'b1;
    bus.auto_mode  = 1'b0;
    bus.sw_reg_id  = 5'd7;
    reset = 1'b1;
    clk(3);
    check("rst_view_valid", 32'(bus.view_valid), 0);
    check("rst_view_data", bus.view_data, 0);
    check("rst_view_id", 32'(bus.view_id), 0);
    check("rst_reg_out_id", 32'(bus.reg_out_id), 0);
    check("rst_cpu_step", 32'(bus.cpu_step), 0);

    // Init + manual selection of register 7 after reset release.
    reset = 1'b0;
    wait_view(5'd7, 8, ok);
    check("init_sw7_timeout", 32'(ok), 1);
    check("init_sw7_data", bus.view_data, exp_val(5'd7));
    last_id = 5'd7;

    // Bouncing press then a clean hold: one pulse, and a refresh capture.
    core_gen = 8'd1;
    p0 = pulses;
    bounce(6);
    bus.step_key_n = 1'b0;
    check("bounce_press_no_pulse", 32'(pulses - p0), 0);
    clk(10);
    check("press_one_pulse", 32'(pulses - p0), 1);
    clk(5);
    check("press_refresh_data", bus.view_data, exp_val(5'd7));
    p0 = pulses;
    bounce(6);
    bus.step_key_n = 1'b1;
    clk(10);
    check("release_no_pulse", 32'(pulses - p0), 0);

    // Random manual selections.
    for (int i = 0; i < 6; i++) begin
      last_id = reg_id_t'($urandom_range(0, 31));
      bus.sw_reg_id = last_id;
      wait_view(last_id, 12, ok);
      check("rand_manual_timeout", 32'(ok), 1);
      check("rand_manual_data", bus.view_data, exp_val(last_id));
      check("rand_manual_regout", 32'(bus.reg_out_id), 32'(last_id));
    end

    // Step pulse lands in SETUP of a manual-change capture: refresh follows.
    id_b = last_id ^ 5'h10;
    bus.step_key_n = 1'b0;
    t0 = cyc;
    clk(3);
    bus.sw_reg_id = id_b;
    clk(5);
    check("setup_step_align", 32'(last_step_cyc), 32'(t0 + 6));
    check("setup_capture_id", 32'(bus.view_id), 32'(id_b));
    check("setup_capture_data", bus.view_data, exp_val(id_b));
    core_gen = core_gen + 8'd1;
    clk(3);
    check("setup_refresh_data", bus.view_data, exp_val(id_b));
    bus.step_key_n = 1'b1;
    clk(8);

    // Reset while in CAPTURE clears everything at once; init follows release.
    id_c = id_b ^ 5'h01;
    bus.sw_reg_id = id_c;
    clk(4);
    check("capture_regout", 32'(bus.reg_out_id), 32'(id_c));
    reset = 1'b1;
    core_gen = 8'd0;
    #1;
    check("midrst_view_data", bus.view_data, 0);
    check("midrst_view_valid", 32'(bus.view_valid), 0);
    check("midrst_view_id", 32'(bus.view_id), 0);
    check("midrst_reg_out_id", 32'(bus.reg_out_id), 0);
    clk(2);
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i <= 6 && !ok; i++) begin
      if (bus.view_valid === 1'b1) ok = 1'b1;
      else if (i < 6) clk(1);
    end
    check("post_rst_init_capture", 32'(ok), 1);
    wait_view(id_c, 12, ok);
    check("post_rst_manual_timeout", 32'(ok), 1);
    check("post_rst_manual_data", bus.view_data, exp_val(id_c));

    // Auto scan from 30: 31, wrap to 0, then 1, DWELL+2 cycles apart.
    bus.sw_reg_id = 5'd30;
    wait_view(5'd30, 12, ok);
    check("auto_prep_timeout", 32'(ok), 1);
    bus.auto_mode = 1'b1;
    wait_view(5'd31, 20, ok);
    check("auto_31_timeout", 32'(ok), 1);
    t0 = cyc;
    wait_view(5'd0, 12, ok);
    check("auto_0_timeout", 32'(ok), 1);
    check("auto_period_31_0", 32'(cyc - t0), DWELL + 2);
    check("auto_wrap_data", bus.view_data, 32'h1000_0000);
    t0 = cyc;
    wait_view(5'd1, 12, ok);
    check("auto_1_timeout", 32'(ok), 1);
    check("auto_period_0_1", 32'(cyc - t0), DWELL + 2);
    check("auto_1_data", bus.view_data, exp_val(5'd1));

    // Step pulse in the same cycle as the advance trigger: one capture only.
    clk(1);
    bus.step_key_n = 1'b0;
    t0 = cyc;
    p0 = pulses;
    e = exp_val(5'd2);
    clk(9);
    check("simul_step_align", 32'(last_step_cyc), 32'(t0 + 6));
    check("simul_adv_id", 32'(bus.view_id), 2);
    check("simul_adv_data", bus.view_data, e);
    core_gen = core_gen + 8'd1;
    clk(7);
    check("simul_no_refresh_id", 32'(bus.view_id), 2);
    check("simul_no_refresh_data", bus.view_data, e);
    check("simul_one_pulse", 32'(pulses - p0), 1);

    bus.step_key_n = 1'b1;
    bus.auto_mode  = 1'b0;
    clk(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
